// File: rtl/demo_bus_pkg.sv
// Shared constants for the demo CPU bus responder: I/O register map, TCTRL/STATUS bit positions.
// Latency: n/a (constants only).
// Backpressure: n/a.
package demo_bus_pkg;

  localparam logic [15:0] IO_BASE     = 16'hC000;
  localparam logic [15:0] ADDR_LED    = IO_BASE + 16'h0000;
  localparam logic [15:0] ADDR_KEYS   = IO_BASE + 16'h0001;
  localparam logic [15:0] ADDR_TMR_LO = IO_BASE + 16'h0002;
  localparam logic [15:0] ADDR_TMR_HI = IO_BASE + 16'h0003;
  localparam logic [15:0] ADDR_TCTRL  = IO_BASE + 16'h0004;
  localparam logic [15:0] ADDR_TXD    = IO_BASE + 16'h0005;
  localparam logic [15:0] ADDR_STATUS = IO_BASE + 16'h0006;

  // TCTRL bit positions
  localparam int TCTRL_EN     = 0;
  localparam int TCTRL_IRQ_EN = 1;
  localparam int TCTRL_FLAG   = 7;

  // STATUS bit positions (count lives in [2:0])
  localparam int STATUS_FULL  = 3;
  localparam int STATUS_EMPTY = 4;
  localparam int STATUS_OVF   = 5;
  localparam int STATUS_TFLAG = 7;

  localparam logic [7:0] UNMAPPED_READ = 8'hFF;

endpackage

// File: rtl/demo_tx_fifo.sv
// Synchronous byte FIFO feeding the serial transmitter; head is shown combinationally from storage.
// Latency: a pushed byte is visible at head/valid one cycle after the push edge.
// Backpressure: a push while full is dropped and sets sticky overflow unless a pop happens on the same edge.
// Ports: clk/reset (sync, active-high); push/push_dat write side; ready/head/valid drain side;
//        count (entries mod DEPTH), full, empty, overflow status; ovf_clear clears overflow.
module demo_tx_fifo #(
  parameter int DEPTH = 4,  // power of two, at least 2
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               push_dat,
  input  logic                       ready,
  output logic [W-1:0]               head,
  output logic                       valid,
  output logic [$clog2(DEPTH)-1:0]   count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  input  logic                       ovf_clear
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          pop_fire, push_fire;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // Only the low bits are reported; a full FIFO reads as count 0 with full set.
  assign count     = wr_ptr[AW-1:0] - rd_ptr[AW-1:0];
  assign valid     = !empty;
  assign head      = mem[rd_ptr[AW-1:0]];

  assign pop_fire  = ready && !empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign push_fire = push && (!full || pop_fire);

  always_ff @(posedge clk) begin
    if (!reset && push_fire) begin
      mem[wr_ptr[AW-1:0]] <= push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + 1'b1;
      if (pop_fire)  rd_ptr <= rd_ptr + 1'b1;
      // A dropped push on the same edge as a clear keeps overflow set.
      if (push && !push_fire) begin
        overflow <= 1'b1;
      end else if (ovf_clear) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/demo_bus_responder.sv
// Slave end of the demo CPU bus: RAM, LED/key port, prescaled 16-bit timer with irq, transmit FIFO.
// Latency: o_data is registered, valid the cycle after the address; writes commit on the strobe edge.
// Backpressure: none on the CPU bus; TX FIFO drains by valid/ready and drops pushes when full (sticky overflow).
// Ports: clock_25/reset (sync, active-high); i_addr/i_data/i_wr/o_data CPU bus; o_led/i_keys board I/O;
//        o_irq timer interrupt level; o_tx_data/o_tx_valid/i_tx_ready transmitter handshake.
module demo_bus_responder #(
  parameter int RAM_AW     = 12,
  parameter int PRESCALE   = 25000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock_25,
  input  logic        reset,
  input  logic [15:0] i_addr,
  input  logic [7:0]  i_data,
  input  logic        i_wr,
  output logic [7:0]  o_data,
  output logic [7:0]  o_led,
  input  logic [7:0]  i_keys,
  output logic        o_irq,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready
);
  import demo_bus_pkg::*;

  localparam int PW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam int FAW = $clog2(FIFO_DEPTH);

  // ---------------- decode ----------------
  logic              ram_sel;
  logic [RAM_AW-1:0] ram_idx;
  logic              led_we, tctrl_we, txd_we, status_we, lo_rd;

  assign ram_sel   = ((i_addr >> RAM_AW) == 16'd0);
  assign ram_idx   = i_addr[RAM_AW-1:0];
  assign led_we    = i_wr && (i_addr == ADDR_LED);
  assign tctrl_we  = i_wr && (i_addr == ADDR_TCTRL);
  assign txd_we    = i_wr && (i_addr == ADDR_TXD);
  assign status_we = i_wr && (i_addr == ADDR_STATUS);
  assign lo_rd     = !i_wr && (i_addr == ADDR_TMR_LO);

  // ---------------- RAM (contents survive reset) ----------------
  logic [7:0] ram [2**RAM_AW];

  always_ff @(posedge clock_25) begin
    if (!reset && i_wr && ram_sel) begin
      ram[ram_idx] <= i_data;
    end
  end

  // ---------------- LED and key synchroniser ----------------
  logic [7:0] keys_meta, keys_sync;

  always_ff @(posedge clock_25) begin
    if (reset) begin
      o_led     <= '0;
      keys_meta <= '0;
      keys_sync <= '0;
    end else begin
      if (led_we) o_led <= i_data;
      keys_meta <= i_keys;
      keys_sync <= keys_meta;
    end
  end

  // ---------------- timer ----------------
  logic [PW-1:0] presc;
  logic [15:0]   counter;
  logic [7:0]    shadow;
  logic          t_en, t_irq_en, t_flag;
  logic          tick, wrap;

  assign tick = t_en && (presc == PRESC_LAST);
  assign wrap = tick && (counter == 16'hFFFF);

  always_ff @(posedge clock_25) begin
    if (reset) begin
      presc    <= '0;
      counter  <= '0;
      shadow   <= '0;
      t_en     <= 1'b0;
      t_irq_en <= 1'b0;
      t_flag   <= 1'b0;
      o_irq    <= 1'b0;
    end else begin
      if (t_en) presc <= tick ? '0 : presc + 1'b1;
      if (tick) counter <= counter + 16'd1;
      if (tctrl_we) begin
        t_en     <= i_data[TCTRL_EN];
        t_irq_en <= i_data[TCTRL_IRQ_EN];
      end
      // A wrap on the same edge as a software clear wins, so no wrap is lost.
      if (wrap) begin
        t_flag <= 1'b1;
      end else if (tctrl_we && i_data[TCTRL_FLAG]) begin
        t_flag <= 1'b0;
      end
      // Latch the high byte when the low byte is read so LO-then-HI is atomic.
      if (lo_rd) shadow <= counter[15:8];
      o_irq <= t_flag && t_irq_en;
    end
  end

  // ---------------- transmit FIFO ----------------
  logic [FAW-1:0] fifo_cnt;
  logic           fifo_full, fifo_empty, fifo_ovf;

  demo_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_tx_fifo (
    .clk       (clock_25),
    .reset     (reset),
    .push      (txd_we),
    .push_dat  (i_data),
    .ready     (i_tx_ready),
    .head      (o_tx_data),
    .valid     (o_tx_valid),
    .count     (fifo_cnt),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .overflow  (fifo_ovf),
    .ovf_clear (status_we)
  );

  // ---------------- read path ----------------
  logic [7:0] tctrl_val, status_val, io_rdata;

  always_comb begin
    tctrl_val               = '0;
    tctrl_val[TCTRL_EN]     = t_en;
    tctrl_val[TCTRL_IRQ_EN] = t_irq_en;
    tctrl_val[TCTRL_FLAG]   = t_flag;

    status_val               = '0;
    status_val[2:0]          = 3'(fifo_cnt);
    status_val[STATUS_FULL]  = fifo_full;
    status_val[STATUS_EMPTY] = fifo_empty;
    status_val[STATUS_OVF]   = fifo_ovf;
    status_val[STATUS_TFLAG] = t_flag;

    io_rdata = UNMAPPED_READ;
    case (i_addr)
      ADDR_LED:    io_rdata = o_led;
      ADDR_KEYS:   io_rdata = keys_sync;
      ADDR_TMR_LO: io_rdata = counter[7:0];
      ADDR_TMR_HI: io_rdata = shadow;
      ADDR_TCTRL:  io_rdata = tctrl_val;
      ADDR_STATUS: io_rdata = status_val;
      default:     io_rdata = UNMAPPED_READ;
    endcase
  end

  always_ff @(posedge clock_25) begin
    if (reset) begin
      o_data <= '0;
    end else begin
      o_data <= ram_sel ? ram[ram_idx] : io_rdata;
    end
  end

endmodule

// File: tb/tb_demo_bus_responder.sv
module tb_demo_bus_responder;

  localparam int PRESC = 1;

  logic        clock_25 = 1'b0;
  logic        reset    = 1'b1;
  logic [15:0] i_addr   = '0;
  logic [7:0]  i_data   = '0;
  logic        i_wr     = 1'b0;
  logic [7:0]  o_data;
  logic [7:0]  o_led;
  logic [7:0]  i_keys   = '0;
  logic        o_irq;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready = 1'b0;

  demo_bus_responder #(
    .RAM_AW     (12),
    .PRESCALE   (PRESC),
    .FIFO_DEPTH (4)
  ) dut (
    .clock_25   (clock_25),
    .reset      (reset),
    .i_addr     (i_addr),
    .i_data     (i_data),
    .i_wr       (i_wr),
    .o_data     (o_data),
    .o_led      (o_led),
    .i_keys     (i_keys),
    .o_irq      (o_irq),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .i_tx_ready (i_tx_ready)
  );

  always #5 clock_25 = ~clock_25;

  // Number of rising edges seen so far.
  int cyc = 0;
  always @(posedge clock_25) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;
  int en_cyc = 0;

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic step();
    @(negedge clock_25);
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    i_addr = a; i_data = d; i_wr = 1'b1;
    step();
    i_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
    i_addr = a; i_wr = 1'b0;
    step();
    d = o_data;
  endtask

  task automatic do_reset();
    reset = 1'b1; i_wr = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  // Timer value after edge m: one count per PRESC enabled edges, modulo 2^16.
  function automatic logic [15:0] tmr_at(input int m);
    return 16'(((m - en_cyc) / PRESC) % 65536);
  endfunction

  task automatic test_reset();
    logic [7:0] d;
    reset = 1'b1; i_wr = 1'b0; i_addr = '0; i_keys = '0; i_tx_ready = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    total++; if (o_data !== 8'h00) $display("FAIL reset_o_data got %h want 00", o_data); else passed++;
    total++; if (o_led !== 8'h00) $display("FAIL reset_o_led got %h want 00", o_led); else passed++;
    total++; if (o_irq !== 1'b0) $display("FAIL reset_o_irq got %b want 0", o_irq); else passed++;
    total++; if (o_tx_valid !== 1'b0) $display("FAIL reset_tx_valid got %b want 0", o_tx_valid); else passed++;
    bus_read(16'hC006, d);
    total++; if (d !== 8'h10) $display("FAIL reset_status got %h want 10", d); else passed++;
    bus_read(16'hC004, d);
    total++; if (d !== 8'h00) $display("FAIL reset_tctrl got %h want 00", d); else passed++;
    bus_read(16'hC002, d);
    total++; if (d !== 8'h00) $display("FAIL reset_tmr_lo got %h want 00", d); else passed++;
    bus_read(16'hC003, d);
    total++; if (d !== 8'h00) $display("FAIL reset_tmr_hi got %h want 00", d); else passed++;
  endtask

  task automatic test_ram();
    logic [7:0]  d;
    logic [7:0]  ram_model [int];
    logic [15:0] a;
    bus_write(16'h0123, 8'h5A);
    bus_read(16'h0123, d);
    total++; if (d !== 8'h5A) $display("FAIL ram_rd got %h want 5A", d); else passed++;
    bus_read(16'h8000, d);
    total++; if (d !== 8'hFF) $display("FAIL unmapped_8000 got %h want FF", d); else passed++;
    // A write on a reset edge must be discarded.
    reset = 1'b1;
    bus_write(16'h0123, 8'h99);
    reset = 1'b0;
    bus_read(16'h0123, d);
    total++; if (d !== 8'h5A) $display("FAIL ram_reset_write got %h want 5A", d); else passed++;
    ram_model[16'h0123] = 8'h5A;
    for (int k = 0; k < 24; k++) begin
      a = 16'($urandom_range(0, 4095));
      d = 8'($urandom);
      ram_model[int'(a)] = d;
      bus_write(a, d);
    end
    foreach (ram_model[ai]) begin
      bus_read(16'(ai), d);
      total++; if (d !== ram_model[ai]) $display("FAIL ram_rand @%h got %h want %h", ai, d, ram_model[ai]); else passed++;
    end
    for (int k = 0; k < 8; k++) begin
      a = (k % 2 == 0) ? 16'($urandom_range(16'h1000, 16'hBFFF)) : 16'($urandom_range(16'hC007, 16'hFFFF));
      bus_write(a, 8'($urandom));
      bus_read(a, d);
      total++; if (d !== 8'hFF) $display("FAIL unmapped_rand @%h got %h want FF", a, d); else passed++;
    end
  endtask

  task automatic test_led_keys();
    logic [7:0] d;
    bus_write(16'hC000, 8'hA5);
    total++; if (o_led !== 8'hA5) $display("FAIL led_out got %h want A5", o_led); else passed++;
    bus_read(16'hC000, d);
    total++; if (d !== 8'hA5) $display("FAIL led_rd got %h want A5", d); else passed++;
    i_keys = 8'h3C;
    i_addr = 16'h0000;
    repeat (3) step();
    bus_read(16'hC001, d);
    total++; if (d !== 8'h3C) $display("FAIL keys_rd got %h want 3C", d); else passed++;
    bus_write(16'hC001, 8'h00);
    bus_read(16'hC001, d);
    total++; if (d !== 8'h3C) $display("FAIL keys_ro got %h want 3C", d); else passed++;
    bus_write(16'hC003, 8'h77);
    bus_read(16'hC003, d);
    total++; if (d !== 8'h00) $display("FAIL tmr_hi_wr got %h want 00", d); else passed++;
    bus_read(16'hC005, d);
    total++; if (d !== 8'hFF) $display("FAIL txd_rd got %h want FF", d); else passed++;
    total++; if (o_tx_valid !== 1'b0) $display("FAIL txd_rd_push got %b want 0", o_tx_valid); else passed++;
  endtask

  task automatic test_fifo_overflow();
    logic [7:0] d;
    i_tx_ready = 1'b0;
    for (int k = 1; k <= 5; k++) bus_write(16'hC005, 8'(k));
    bus_read(16'hC006, d);
    total++; if (d !== 8'h28) $display("FAIL ovf_status got %h want 28", d); else passed++;
    i_addr = 16'h0000;
    i_tx_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      total++; if (o_tx_valid !== 1'b1 || o_tx_data !== 8'(k))
        $display("FAIL drain_%0d got v=%b d=%h want v=1 d=%h", k, o_tx_valid, o_tx_data, 8'(k)); else passed++;
      step();
    end
    total++; if (o_tx_valid !== 1'b0) $display("FAIL drain_empty got %b want 0", o_tx_valid); else passed++;
    i_tx_ready = 1'b0;
    bus_read(16'hC006, d);
    total++; if (d !== 8'h30) $display("FAIL ovf_sticky got %h want 30", d); else passed++;
    bus_write(16'hC006, 8'h00);
    bus_read(16'hC006, d);
    total++; if (d !== 8'h10) $display("FAIL ovf_clear got %h want 10", d); else passed++;
  endtask

  task automatic test_fifo_random();
    logic [7:0] q [$];
    logic       m_ovf;
    logic       do_push, rdy, pop, was_full;
    logic [7:0] dv, d, exp;
    int         n;
    m_ovf = 1'b0;
    for (int k = 0; k < 80; k++) begin
      do_push  = 1'($urandom_range(0, 1));
      rdy      = ($urandom_range(0, 2) == 0);
      dv       = 8'($urandom);
      i_addr = 16'hC005; i_data = dv; i_wr = do_push; i_tx_ready = rdy;
      was_full = (q.size() == 4);
      pop      = rdy && (q.size() > 0);
      if (pop) void'(q.pop_front());
      if (do_push) begin
        if (!was_full || pop) q.push_back(dv);
        else m_ovf = 1'b1;
      end
      step();
      i_wr = 1'b0;
      total++; if (o_tx_valid !== (q.size() != 0)) $display("FAIL rand_valid k=%0d got %b want %b", k, o_tx_valid, q.size() != 0); else passed++;
      if (q.size() != 0) begin
        total++; if (o_tx_data !== q[0]) $display("FAIL rand_head k=%0d got %h want %h", k, o_tx_data, q[0]); else passed++;
      end
    end
    i_tx_ready = 1'b0;
    n   = q.size();
    exp = 8'((n % 4) + ((n == 4) ? 8 : 0) + ((n == 0) ? 16 : 0) + (m_ovf ? 32 : 0));
    bus_read(16'hC006, d);
    total++; if (d !== exp) $display("FAIL rand_status got %h want %h", d, exp); else passed++;
  endtask

  task automatic test_full_push_pop();
    logic [7:0] d;
    i_tx_ready = 1'b0;
    for (int k = 0; k < 4; k++) bus_write(16'hC005, 8'(8'h11 + k));
    bus_read(16'hC006, d);
    total++; if (d !== 8'h08) $display("FAIL full_status got %h want 08", d); else passed++;
    i_tx_ready = 1'b1;
    bus_write(16'hC005, 8'h77);
    i_tx_ready = 1'b0;
    bus_read(16'hC006, d);
    total++; if (d !== 8'h08) $display("FAIL full_pushpop_status got %h want 08", d); else passed++;
    total++; if (o_tx_data !== 8'h12) $display("FAIL full_pushpop_head got %h want 12", o_tx_data); else passed++;
    i_addr = 16'h0000;
    i_tx_ready = 1'b1;
    step();
    total++; if (o_tx_data !== 8'h13) $display("FAIL mid_drain_head got %h want 13", o_tx_data); else passed++;
    reset = 1'b1;
    step();
    total++; if (o_tx_valid !== 1'b0) $display("FAIL reset_mid_drain got %b want 0", o_tx_valid); else passed++;
    reset = 1'b0;
    i_tx_ready = 1'b0;
    bus_read(16'hC006, d);
    total++; if (d !== 8'h10) $display("FAIL post_reset_status got %h want 10", d); else passed++;
  endtask

  task automatic test_timer();
    logic [7:0]  d;
    logic [15:0] exp;
    int          m;
    bus_write(16'hC004, 8'h03);
    en_cyc = cyc;
    i_addr = 16'h0000;
    while ((cyc - en_cyc) < 'h12FF) step();
    m   = cyc;
    exp = tmr_at(m);
    bus_read(16'hC002, d);
    total++; if (d !== exp[7:0] || exp !== 16'h12FF) $display("FAIL tmr_lo got %h want %h", d, exp[7:0]); else passed++;
    i_addr = 16'h0000;
    repeat (20) step();
    bus_read(16'hC003, d);
    total++; if (d !== exp[15:8]) $display("FAIL tmr_hi_shadow got %h want %h", d, exp[15:8]); else passed++;
    m   = cyc;
    exp = tmr_at(m);
    bus_read(16'hC002, d);
    total++; if (d !== exp[7:0]) $display("FAIL tmr_lo2 got %h want %h", d, exp[7:0]); else passed++;
    i_addr = 16'h0000;
    step();
    bus_read(16'hC003, d);
    total++; if (d !== exp[15:8]) $display("FAIL tmr_hi2 got %h want %h", d, exp[15:8]); else passed++;
    i_addr = 16'h0000;
    while ((cyc - en_cyc) < 'hFFFF) step();
    total++; if (o_irq !== 1'b0) $display("FAIL irq_prewrap got %b want 0", o_irq); else passed++;
    bus_read(16'hC004, d);
    total++; if (d !== 8'h03) $display("FAIL tctrl_prewrap got %h want 03", d); else passed++;
    total++; if (o_irq !== 1'b0) $display("FAIL irq_wrap_edge got %b want 0", o_irq); else passed++;
    bus_read(16'hC004, d);
    total++; if (d !== 8'h83) $display("FAIL tctrl_wrap got %h want 83", d); else passed++;
    total++; if (o_irq !== 1'b1) $display("FAIL irq_set got %b want 1", o_irq); else passed++;
    bus_read(16'hC006, d);
    total++; if (d !== 8'h90) $display("FAIL status_tflag got %h want 90", d); else passed++;
    m   = cyc;
    exp = tmr_at(m);
    bus_read(16'hC002, d);
    total++; if (d !== exp[7:0]) $display("FAIL tmr_postwrap got %h want %h", d, exp[7:0]); else passed++;
    bus_write(16'hC004, 8'h83);
    i_addr = 16'h0000;
    step();
    total++; if (o_irq !== 1'b0) $display("FAIL irq_clear got %b want 0", o_irq); else passed++;
    bus_read(16'hC004, d);
    total++; if (d !== 8'h03) $display("FAIL tctrl_clear got %h want 03", d); else passed++;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired passed=%0d total=%0d", passed, total);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_ram();
    test_led_keys();
    test_fifo_overflow();
    test_fifo_random();
    do_reset();
    test_full_push_pop();
    test_timer();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/demo_bus_responder.md
Name: demo_bus_responder

Overview:
- Slave end of the 8-bit CPU bus used by the demo processor, which drives a 16-bit address, 8-bit write data and a write strobe, and reads 8-bit data.
- Decodes every bus cycle into four targets: on-chip RAM, an LED/key I/O port, a 16-bit prescaled timer with interrupt, and a 4-deep transmit byte FIFO.
- The FIFO is drained by an external serial transmitter through a valid/ready handshake.
- Sits between the CPU core and the board peripherals; it is the only device on the bus.

Parameters:
- RAM_AW, 12, RAM address width; RAM occupies 0x0000 to 2^RAM_AW-1.
- PRESCALE, 25000, clock_25 cycles per timer tick (1 ms), minimum 1.
- FIFO_DEPTH, 4, transmit FIFO entries; must be a power of two.

Ports:
- clock_25  in  1  system clock, 25 MHz.
- reset  in  1  synchronous reset, active-high.
- i_addr  in  16  bus address from the CPU.
- i_data  in  8  write data from the CPU.
- i_wr  in  1  write strobe; the write commits on the rising edge when this is 1.
- o_data  out  8  read data to the CPU, registered.
- o_led  out  8  LED output register.
- i_keys  in  8  key inputs, sampled through a 2-flop synchroniser.
- o_irq  out  1  timer interrupt request, level.
- o_tx_data  out  8  FIFO head byte.
- o_tx_valid  out  1  FIFO not empty.
- i_tx_ready  in  1  consumer accepts the head byte when valid && ready.

Behaviour:
- Read latency:
  - o_data is registered with 1-cycle latency and is valid in cycle N+1 for the address presented in cycle N.
  - Reads have no side effects except those listed below.
- Address map:
  - RAM is 0x0000..2^RAM_AW-1.
  - I/O registers are 0xC000..0xC006.
  - All other reads return 0xFF; all other writes are ignored.
- 0xC000 LED: read/write.
- 0xC001 KEYS: read-only; returns the synchronised keys.
- 0xC002 TMR_LO:
  - Reading returns counter[7:0] and latches counter[15:8] into a shadow register.
- 0xC003 TMR_HI:
  - Reading returns the shadow byte, so a LO-then-HI read pair is atomic.
  - Writing has no effect.
- 0xC004 TCTRL:
  - bit0 = enable, bit1 = irq_en, bit7 = wrap flag.
  - Writing bit7=1 clears the flag.
  - If a wrap and a clear occur in the same cycle, the flag stays set.
- 0xC005 TXD:
  - Writing pushes a byte to the FIFO.
  - Reading returns 0xFF.
- 0xC006 STATUS:
  - bit[2:0] = FIFO count, bit3 = full, bit4 = empty, bit5 = overflow (sticky), bit7 = timer flag.
  - Writing any value clears overflow.
- Timer:
  - When enable=1, the prescaler counts 0..PRESCALE-1; the counter increments when the prescaler reaches PRESCALE-1.
  - The counter wraps 0xFFFF -> 0x0000 and sets the flag on wrap.
  - Clearing enable freezes both the prescaler and the counter.
  - o_irq = flag & irq_en, registered.
- FIFO:
  - A push while full is dropped and sets overflow, except when a pop occurs in the same cycle, in which case the push is accepted.
  - Push and pop in the same cycle while empty: the pop is impossible (valid=0) and the push is accepted.
  - o_tx_data always equals the head entry; it is don't-care when empty.
- Reset values:
  - o_data=0x00, o_led=0x00, o_irq=0, o_tx_valid=0.
  - Counter, prescaler, shadow and TCTRL are 0; the FIFO is empty; overflow=0.
  - RAM contents are not reset.
  - A reset asserted mid-operation discards any pending write on that edge.

Decomposition:
- Package demo_bus_pkg holds:
  - the address constants ADDR_LED, ADDR_KEYS, ADDR_TMR_LO, ADDR_TMR_HI, ADDR_TCTRL, ADDR_TXD, ADDR_STATUS;
  - IO_BASE = 16'hC000;
  - the TCTRL bit positions;
  - UNMAPPED_READ = 8'hFF.
- Sub-module demo_tx_fifo contains the parameterised sync FIFO with push/pop, count, full, empty and overflow.
- The RAM is an inferred single-port synchronous array inside the top module.

Test Plan:
- Reset, then write 0x5A to 0x0123, then read 0x0123 -> o_data=0x5A one cycle after the address; reading 0x8000 -> 0xFF.
- Write 0xA5 to 0xC000 -> o_led=0xA5; drive i_keys=0x3C for 3 cycles, read 0xC001 -> 0x3C.
- PRESCALE=1, TCTRL=0x03, counter preloaded by run-time to 0xFFFF -> wraps to 0x0000, TCTRL bit7=1, o_irq=1 next cycle; write 0x83 -> flag and o_irq clear.
- Read TMR_LO at counter=0x12FF, then let the counter advance past 0x1300 and read TMR_HI -> 0x12 (shadow, not 0x13).
- i_tx_ready=0, push 5 bytes 0x01..0x05 -> STATUS=0x28 (count wraps to 0, full, overflow); raise ready -> 0x01..0x04 emitted in order, then o_tx_valid=0.
- FIFO full, push 0x77 with i_tx_ready=1 in the same cycle -> push accepted, overflow stays 0, count stays 4; assert reset mid-drain -> o_tx_valid=0 next cycle.
